writeback: RTL and testbench

//  Final (WB) stage of the MIPS pipeline, directly downstream of the memory stage.

---
 rtl/writeback_pkg.sv | 27 ++
 rtl/writeback_if.sv | 45 ++++
 rtl/wb_load_align.sv | 78 +++++++
 rtl/writeback.sv | 167 ++++++++++++++++
 tb/tb_writeback.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_pkg.sv
// writeback_pkg
//  Shared constants for the MIPS write-back stage: datapath and register
//  address widths, retired-counter width, load-type encodings and the WB
//  entry state encoding.
//  Optional feature macro used by the files of this slice: WB_SUBWORD_EN
//  (byte/halfword load formatting; when undefined every load is a word load).
package writeback_pkg;

    localparam int DWIDTH     = 32;
    localparam int AWIDTH_REG = 5;
    localparam int CNT_WIDTH  = 32;

    // Load-type encodings as carried by the MEM stage (bit 2 = unsigned).
    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    // WB entry state: nothing, a live entry, or a live entry frozen by a stall.
    typedef enum logic [1:0] {
        WB_EMPTY = 2'b00,
        WB_VALID = 2'b01,
        WB_HELD  = 2'b10
    } wb_state_e;

endpackage

// File: rtl/writeback_if.sv
// writeback_if
//  MEM -> WB handshake/data bundle plus the WB register-file write and
//  forwarding outputs.
//  master : MEM stage / hazard unit side (drives w_i_*, observes w_o_*)
//  slave  : writeback stage (observes w_i_*, drives w_o_*)
//  Signals: w_i_ce, w_i_stall, w_i_flush, w_i_alu_value, w_i_rd_addr,
//           w_i_reg_wr, w_i_mem_to_reg, w_i_load_type, w_i_load_data,
//           w_o_valid, w_o_rd_addr, w_o_rd_data, w_o_reg_wr,
//           w_o_misalign, w_o_retired
interface writeback_if #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH_REG = 5,
    parameter int CNT_WIDTH  = 32
);
    logic                  w_i_ce;
    logic                  w_i_stall;
    logic                  w_i_flush;
    logic [DWIDTH-1:0]     w_i_alu_value;
    logic [AWIDTH_REG-1:0] w_i_rd_addr;
    logic                  w_i_reg_wr;
    logic                  w_i_mem_to_reg;
    logic [2:0]            w_i_load_type;
    logic [DWIDTH-1:0]     w_i_load_data;

    logic                  w_o_valid;
    logic [AWIDTH_REG-1:0] w_o_rd_addr;
    logic [DWIDTH-1:0]     w_o_rd_data;
    logic                  w_o_reg_wr;
    logic                  w_o_misalign;
    logic [CNT_WIDTH-1:0]  w_o_retired;

    modport master (
        output w_i_ce, w_i_stall, w_i_flush, w_i_alu_value, w_i_rd_addr,
               w_i_reg_wr, w_i_mem_to_reg, w_i_load_type, w_i_load_data,
        input  w_o_valid, w_o_rd_addr, w_o_rd_data, w_o_reg_wr,
               w_o_misalign, w_o_retired
    );

    modport slave (
        input  w_i_ce, w_i_stall, w_i_flush, w_i_alu_value, w_i_rd_addr,
               w_i_reg_wr, w_i_mem_to_reg, w_i_load_type, w_i_load_data,
        output w_o_valid, w_o_rd_addr, w_o_rd_data, w_o_reg_wr,
               w_o_misalign, w_o_retired
    );
endinterface

// File: rtl/wb_load_align.sv
// wb_load_align
//  Combinational load formatter for the write-back stage.
//  Ports: load_type (only with WB_SUBWORD_EN), addr (effective address bits
//  [1:0]), raw_data (memory read word) -> fmt_data (lane-selected and
//  extended value), misalign (access not naturally aligned).
//  WB_SUBWORD_EN defined : LB/LH sign-extend, LBU/LHU zero-extend, little-endian
//                          lanes; unknown encodings behave as LW.
//  WB_SUBWORD_EN undefined: word loads only, misaligned when addr != 0.
module wb_load_align #(
    parameter int DWIDTH = writeback_pkg::DWIDTH
) (
`ifdef WB_SUBWORD_EN
    input  logic [2:0]        load_type,
`endif
    input  logic [1:0]        addr,
    input  logic [DWIDTH-1:0] raw_data,
    output logic [DWIDTH-1:0] fmt_data,
    output logic              misalign
);
    import writeback_pkg::*;

`ifdef WB_SUBWORD_EN
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane extraction: byte lane = addr[1:0], half lane = addr[1].
    always_comb begin
        byte_s = raw_data[7:0];
        case (addr)
            2'b00:   byte_s = raw_data[7:0];
            2'b01:   byte_s = raw_data[15:8];
            2'b10:   byte_s = raw_data[23:16];
            2'b11:   byte_s = raw_data[31:24];
            default: byte_s = raw_data[7:0];
        endcase
        if (addr[1]) begin
            half_s = raw_data[31:16];
        end else begin
            half_s = raw_data[15:0];
        end
    end

    // Extension and alignment check per load type.
    always_comb begin
        fmt_data = raw_data;
        misalign = 1'b0;
        case (load_type)
            LT_LB: begin
                fmt_data = {{(DWIDTH-8){byte_s[7]}}, byte_s};
                misalign = 1'b0;
            end
            LT_LBU: begin
                fmt_data = {{(DWIDTH-8){1'b0}}, byte_s};
                misalign = 1'b0;
            end
            LT_LH: begin
                fmt_data = {{(DWIDTH-16){half_s[15]}}, half_s};
                misalign = addr[0];
            end
            LT_LHU: begin
                fmt_data = {{(DWIDTH-16){1'b0}}, half_s};
                misalign = addr[0];
            end
            default: begin
                fmt_data = raw_data;
                misalign = (addr != 2'b00);
            end
        endcase
    end
`else
    // Word-only build: data passes through, any nonzero byte offset is misaligned.
    always_comb begin
        fmt_data = raw_data;
        misalign = (addr != 2'b00);
    end
`endif

endmodule

// File: rtl/writeback.sv
// writeback
//  Final (WB) stage of the MIPS pipeline. Holds the MEM/WB pipeline register,
//  formats data returned by the synchronous-read data memory (one cycle after
//  capture), selects ALU result vs load data and drives the register-file
//  write port / forwarding path. Stall and flush aware; counts retirements.
//  Ports: w_clk (rising edge), w_rst (async, active-high),
//         bus (writeback_if.slave: MEM-stage inputs w_i_*, WB outputs w_o_*).
//  Optional feature macro: WB_SUBWORD_EN (sub-word load formatting).
module writeback #(
    parameter int DWIDTH     = writeback_pkg::DWIDTH,
    parameter int AWIDTH_REG = writeback_pkg::AWIDTH_REG,
    parameter int CNT_WIDTH  = writeback_pkg::CNT_WIDTH
) (
    input  logic        w_clk,
    input  logic        w_rst,
    writeback_if.slave  bus
);
    import writeback_pkg::*;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    wb_state_e             state_r;
    wb_state_e             state_nxt_s;
    logic                  capture_s;
    logic                  hold_load_s;
    logic                  live_s;
    logic                  commit_s;
    logic [DWIDTH-1:0]     alu_r;
    logic [DWIDTH-1:0]     hold_r;
    logic [DWIDTH-1:0]     fmt_data_s;
    logic [DWIDTH-1:0]     result_s;
    logic [DWIDTH-1:0]     rd_data_s;
    logic [AWIDTH_REG-1:0] rd_r;
    logic                  reg_wr_r;
    logic                  mem_to_reg_r;
    logic                  fmt_mis_s;
    logic                  misalign_s;
    logic [CNT_WIDTH-1:0]  retired_r;

`ifdef WB_SUBWORD_EN
    logic [2:0]            load_type_r;
`else
    logic [2:0]            unused_load_type_s;
    assign unused_load_type_s = bus.w_i_load_type;
`endif

    // Load data arrives the cycle after capture, so it is formatted live from
    // the memory output using the registered address and type.
    wb_load_align #(
        .DWIDTH    (DWIDTH)
    ) u_align (
`ifdef WB_SUBWORD_EN
        .load_type (load_type_r),
`endif
        .addr      (alu_r[1:0]),
        .raw_data  (bus.w_i_load_data),
        .fmt_data  (fmt_data_s),
        .misalign  (fmt_mis_s)
    );

    // Result selection, live/commit qualification.
    always_comb begin
        result_s   = alu_r;
        misalign_s = 1'b0;
        if (mem_to_reg_r) begin
            result_s   = fmt_data_s;
            misalign_s = fmt_mis_s;
        end else begin
            result_s   = alu_r;
            misalign_s = 1'b0;
        end
        live_s   = (state_r != WB_EMPTY);
        commit_s = live_s & ~bus.w_i_stall & ~bus.w_i_flush;
    end

    // Next-state logic; priority flush > stall > capture.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        hold_load_s = 1'b0;
        if (bus.w_i_flush) begin
            state_nxt_s = WB_EMPTY;
        end else if (bus.w_i_stall) begin
            case (state_r)
                WB_VALID: begin
                    // Memory output may change while stalled: freeze the result now.
                    state_nxt_s = WB_HELD;
                    hold_load_s = 1'b1;
                end
                WB_HELD:  state_nxt_s = WB_HELD;
                WB_EMPTY: state_nxt_s = WB_EMPTY;
                default:  state_nxt_s = WB_EMPTY;
            endcase
        end else if (bus.w_i_ce) begin
            state_nxt_s = WB_VALID;
            capture_s   = 1'b1;
        end else begin
            state_nxt_s = WB_EMPTY;
        end
    end

    // State register.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state_r <= WB_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // MEM/WB pipeline register, loaded only on capture.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            alu_r        <= {DWIDTH{1'b0}};
            rd_r         <= {AWIDTH_REG{1'b0}};
            reg_wr_r     <= 1'b0;
            mem_to_reg_r <= 1'b0;
`ifdef WB_SUBWORD_EN
            load_type_r  <= LT_LW;
`endif
        end else if (capture_s) begin
            alu_r        <= bus.w_i_alu_value;
            rd_r         <= bus.w_i_rd_addr;
            reg_wr_r     <= bus.w_i_reg_wr;
            mem_to_reg_r <= bus.w_i_mem_to_reg;
`ifdef WB_SUBWORD_EN
            load_type_r  <= bus.w_i_load_type;
`endif
        end
    end

    // Hold register for the result of a stalled entry.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            hold_r <= {DWIDTH{1'b0}};
        end else if (hold_load_s) begin
            hold_r <= result_s;
        end
    end

    // Retired-instruction counter; misaligned loads still retire.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            retired_r <= {CNT_WIDTH{1'b0}};
        end else if (commit_s) begin
            retired_r <= retired_r + CNT_ONE;
        end
    end

    // Write-data source: live memory/ALU result, frozen hold value, or zero.
    always_comb begin
        rd_data_s = {DWIDTH{1'b0}};
        case (state_r)
            WB_VALID: rd_data_s = result_s;
            WB_HELD:  rd_data_s = hold_r;
            default:  rd_data_s = {DWIDTH{1'b0}};
        endcase
    end

    assign bus.w_o_valid    = live_s;
    assign bus.w_o_rd_addr  = live_s ? rd_r : {AWIDTH_REG{1'b0}};
    assign bus.w_o_rd_data  = rd_data_s;
    assign bus.w_o_reg_wr   = commit_s & reg_wr_r & (rd_r != {AWIDTH_REG{1'b0}}) & ~misalign_s;
    assign bus.w_o_misalign = live_s & misalign_s;
    assign bus.w_o_retired  = retired_r;

endmodule

// File: tb/tb_writeback.sv
// tb_writeback
//  Randomized and directed stimulus for the writeback stage, checked every
//  cycle (at the falling clock edge) against a behavioural model of the WB
//  entry, plus literal expectations for the documented example cases.
//  Honours WB_SUBWORD_EN when computing expected load formatting.
module tb_writeback;
    import writeback_pkg::*;

    logic w_clk = 1'b0;
    logic w_rst = 1'b1;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    bit chk_en = 1'b0;

    writeback_if #(.DWIDTH(DWIDTH), .AWIDTH_REG(AWIDTH_REG), .CNT_WIDTH(CNT_WIDTH)) bus ();

    writeback #(.DWIDTH(DWIDTH), .AWIDTH_REG(AWIDTH_REG), .CNT_WIDTH(CNT_WIDTH)) dut (
        .w_clk (w_clk),
        .w_rst (w_rst),
        .bus   (bus)
    );

    always #5 w_clk = ~w_clk;

    // Behavioural model of the single WB entry.
    bit          m_live;
    bit          m_held;
    logic [31:0] m_alu;
    logic [31:0] m_hold;
    logic [4:0]  m_rd;
    bit          m_wr;
    bit          m_m2r;
    logic [2:0]  m_lt;
    logic [31:0] m_ret;

    function automatic logic [31:0] m_fmt(input logic [2:0] lt, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] v;
        v = w;
`ifdef WB_SUBWORD_EN
        if (lt == 3'd0 || lt == 3'd4) begin
            v = (w >> (32'd8 * {30'd0, a})) & 32'h0000_00FF;
            if (lt == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (lt == 3'd1 || lt == 3'd5) begin
            v = (w >> (32'd16 * ({30'd0, a} / 32'd2))) & 32'h0000_FFFF;
            if (lt == 3'd1 && v >= 32'h0000_8000) v = v + 32'hFFFF_0000;
        end
`else
        if (lt == 3'd7) v = w;
`endif
        return v;
    endfunction

    function automatic bit m_mis(input logic [2:0] lt, input logic [1:0] a);
`ifdef WB_SUBWORD_EN
        if (lt == 3'd0 || lt == 3'd4) return 1'b0;
        if (lt == 3'd1 || lt == 3'd5) return (a % 2'd2) != 2'd0;
`else
        if (lt == 3'd7) return a != 2'd0;
`endif
        return a != 2'd0;
    endfunction

    function automatic logic [31:0] m_value(input logic [31:0] ld);
        return m_m2r ? m_fmt(m_lt, m_alu[1:0], ld) : m_alu;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        check(name, {31'd0, got}, {31'd0, exp});
    endtask

    task automatic model_reset();
        m_live = 1'b0; m_held = 1'b0; m_alu = 32'd0; m_hold = 32'd0;
        m_rd = 5'd0; m_wr = 1'b0; m_m2r = 1'b0; m_lt = 3'd0; m_ret = 32'd0;
    endtask

    // Advance the model across one rising edge using the inputs held during it.
    task automatic model_edge();
        if (w_rst) begin
            model_reset();
        end else begin
            if (m_live && !bus.w_i_stall && !bus.w_i_flush) m_ret = m_ret + 32'd1;
            if (bus.w_i_flush) begin
                m_live = 1'b0; m_held = 1'b0;
            end else if (bus.w_i_stall) begin
                if (m_live && !m_held) begin
                    m_hold = m_value(bus.w_i_load_data);
                    m_held = 1'b1;
                end
            end else if (bus.w_i_ce) begin
                m_live = 1'b1; m_held = 1'b0;
                m_alu = bus.w_i_alu_value; m_rd = bus.w_i_rd_addr;
                m_wr = bus.w_i_reg_wr; m_m2r = bus.w_i_mem_to_reg; m_lt = bus.w_i_load_type;
            end else begin
                m_live = 1'b0; m_held = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        bit e_mis, e_wr;
        logic [31:0] e_data;
        e_mis  = m_live && m_m2r && m_mis(m_lt, m_alu[1:0]);
        e_wr   = m_live && !bus.w_i_stall && !bus.w_i_flush && m_wr && (m_rd != 5'd0) && !e_mis;
        e_data = !m_live ? 32'd0 : (m_held ? m_hold : m_value(bus.w_i_load_data));
        check1("valid", bus.w_o_valid, m_live);
        check("rd_addr", {27'd0, bus.w_o_rd_addr}, m_live ? {27'd0, m_rd} : 32'd0);
        check("rd_data", bus.w_o_rd_data, e_data);
        check1("reg_wr", bus.w_o_reg_wr, e_wr);
        check1("misalign", bus.w_o_misalign, e_mis);
        check("retired", bus.w_o_retired, m_ret);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge w_clk) begin
        if (chk_en) compare_all();
    end

    task automatic drive(input bit ce, input bit stall, input bit flush, input logic [31:0] alu,
                         input logic [4:0] rd, input bit wr, input bit m2r, input logic [2:0] lt,
                         input logic [31:0] ld);
        bus.w_i_ce = ce; bus.w_i_stall = stall; bus.w_i_flush = flush;
        bus.w_i_alu_value = alu; bus.w_i_rd_addr = rd; bus.w_i_reg_wr = wr;
        bus.w_i_mem_to_reg = m2r; bus.w_i_load_type = lt; bus.w_i_load_data = ld;
    endtask

    task automatic idle(input logic [31:0] ld);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, LT_LW, ld);
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
        model_edge();
    endtask

    logic [2:0]  t_lt  [6];
    logic [1:0]  t_a   [6];
    logic [31:0] t_exp [6];
    logic [2:0]  lt_pool [8];
    logic [31:0] r0;

    initial begin
        t_lt = '{LT_LB, LT_LB, LT_LBU, LT_LH, LT_LHU, LT_LW};
        t_a  = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd0, 2'd0};
`ifdef WB_SUBWORD_EN
        t_exp = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
`else
        t_exp = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
`endif
        lt_pool = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

        idle(32'd0);
        model_reset();

        // Pin the model's formatter to hand-computed values.
        for (int i = 0; i < 6; i++) begin
            check($sformatf("model_fmt%0d", i), m_fmt(t_lt[i], t_a[i], 32'h80FF_7F01), t_exp[i]);
        end
        check1("model_mis_lw2", m_mis(LT_LW, 2'd2), 1'b1);

        // Reset state.
        repeat (2) @(posedge w_clk);
        #1;
        check1("rst_valid", bus.w_o_valid, 1'b0);
        check("rst_data", bus.w_o_rd_data, 32'd0);
        check1("rst_wr", bus.w_o_reg_wr, 1'b0);
        check("rst_retired", bus.w_o_retired, 32'd0);
        @(negedge w_clk);
        w_rst = 1'b0;
        chk_en = 1'b1;

        // ALU op.
        drive(1'b1, 1'b0, 1'b0, 32'h0000_1234, 5'd5, 1'b1, 1'b0, LT_LW, 32'd0);
        tick();
        idle(32'hFFFF_FFFF);
        #2;
        check1("alu_wr", bus.w_o_reg_wr, 1'b1);
        check("alu_rd", {27'd0, bus.w_o_rd_addr}, 32'd5);
        check("alu_data", bus.w_o_rd_data, 32'h0000_1234);

        // Loads against memory word 0x80FF7F01.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b0, {30'h0000_0400, t_a[i]}, 5'd3, 1'b1, 1'b1, t_lt[i], $urandom);
            tick();
            idle(32'h80FF_7F01);
            #2;
            check($sformatf("load%0d", i), bus.w_o_rd_data, t_exp[i]);
        end

        // Stall three cycles with the memory output changing underneath.
        drive(1'b1, 1'b0, 1'b0, 32'h0000_2000, 5'd9, 1'b1, 1'b1, LT_LW, $urandom);
        tick();
        r0 = m_ret;
        drive(1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, LT_LW, 32'hA5A5_F00D);
        #2;
        check1("stall0_wr", bus.w_o_reg_wr, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, LT_LW, 32'h1111_1111);
        #2;
        check("stall1_data", bus.w_o_rd_data, 32'hA5A5_F00D);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, LT_LW, 32'h2222_2222);
        #2;
        check("stall2_data", bus.w_o_rd_data, 32'hA5A5_F00D);
        check1("stall2_wr", bus.w_o_reg_wr, 1'b0);
        tick();
        idle(32'h3333_3333);
        #2;
        check("release_data", bus.w_o_rd_data, 32'hA5A5_F00D);
        check1("release_wr", bus.w_o_reg_wr, 1'b1);
        tick();
        #2;
        check("stall_retired", bus.w_o_retired, r0 + 32'd1);

        // Flush with ce in the same cycle.
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0055, 5'd4, 1'b1, 1'b0, LT_LW, 32'd0);
        tick();
        r0 = m_ret;
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0066, 5'd8, 1'b1, 1'b0, LT_LW, 32'd0);
        #2;
        check1("flush_wr", bus.w_o_reg_wr, 1'b0);
        tick();
        idle(32'd0);
        #2;
        check1("flush_valid", bus.w_o_valid, 1'b0);
        check("flush_retired", bus.w_o_retired, r0);

        // Misaligned word load.
        drive(1'b1, 1'b0, 1'b0, 32'h0000_3002, 5'd7, 1'b1, 1'b1, LT_LW, 32'd0);
        tick();
        idle($urandom);
        #2;
        r0 = m_ret;
        check1("mis_flag", bus.w_o_misalign, 1'b1);
        check1("mis_wr", bus.w_o_reg_wr, 1'b0);
        tick();
        #2;
        check("mis_retired", bus.w_o_retired, r0 + 32'd1);

        // Write to r0 is suppressed.
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0077, 5'd0, 1'b1, 1'b0, LT_LW, 32'd0);
        tick();
        idle(32'd0);
        #2;
        check1("r0_valid", bus.w_o_valid, 1'b1);
        check1("r0_wr", bus.w_o_reg_wr, 1'b0);

        // Asynchronous reset with a live entry.
        drive(1'b1, 1'b0, 1'b0, 32'h0000_DEAD, 5'd6, 1'b1, 1'b0, LT_LW, 32'd0);
        tick();
        idle(32'd0);
        #2;
        check1("pre_rst_valid", bus.w_o_valid, 1'b1);
        w_rst = 1'b1;
        model_reset();
        #1;
        check1("arst_valid", bus.w_o_valid, 1'b0);
        check("arst_data", bus.w_o_rd_data, 32'd0);
        check("arst_rd", {27'd0, bus.w_o_rd_addr}, 32'd0);
        check1("arst_wr", bus.w_o_reg_wr, 1'b0);
        check("arst_retired", bus.w_o_retired, 32'd0);
        @(negedge w_clk);
        #1;
        w_rst = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0,
                  $urandom, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  lt_pool[$urandom_range(0, 7)], $urandom);
            tick();
        end
        idle(32'd0);
        tick();
        @(negedge w_clk);
        #1;
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
